// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants: general-purpose register sizing and the
// index of the base-address register R0.
package cpu_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned NUM_GPR    = 16;
  localparam int unsigned GPR_ADDR_W = 4;
  localparam int unsigned R0_IDX     = 0;

endpackage : cpu_pkg

// File: rtl/reg_file_rdport.sv
// One combinational read port of the register file.
// Ports:
//   rd_addr  - register index to read
//   ba_out   - base-address mode; forces R0 to read as zero
//   fwd_en   - a write is being committed this cycle (wr_en and not in reset)
//   wr_addr  - index of the write being committed
//   wr_data  - data of the write being committed
//   regs     - stored register contents
//   busy_vec - registered scoreboard bits
//   rd_data  - selected read data
//   busy     - busy bit of rd_addr (registered state, never forwarded)
module reg_file_rdport
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH  = WORD_W,
  parameter int unsigned DEPTH  = NUM_GPR,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned BYPASS = 1
) (
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              ba_out,
  input  logic              fwd_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [WIDTH-1:0]  regs [DEPTH],
  input  logic [DEPTH-1:0]  busy_vec,
  output logic [WIDTH-1:0]  rd_data,
  output logic              busy
);

  // R0 gating beats forwarding, forwarding beats storage.
  always_comb begin
    rd_data = regs[rd_addr];
    if (ba_out && (rd_addr == ADDR_W'(R0_IDX))) begin
      rd_data = '0;
    end else if ((BYPASS != 0) && fwd_en && (wr_addr == rd_addr)) begin
      rd_data = wr_data;
    end
  end

  assign busy = busy_vec[rd_addr];

endmodule : reg_file_rdport

// File: rtl/reg_file_gen.sv
// Parametrised general-purpose register file with one synchronous write port,
// two combinational read ports (A/B), optional write-to-read bypass, R0 gating
// under BAout, and a busy-bit scoreboard (reserve at issue, release on write).
// Ports:
//   clk, clr             - clock, synchronous active-low reset
//   wr_en/wr_addr/wr_data - write port
//   rd_addr_a/rd_data_a  - read port A
//   rd_addr_b/rd_data_b  - read port B
//   BAout                - base-address mode, R0 reads as zero on both ports
//   rsv_en/rsv_addr      - reserve (mark busy) a destination register
//   busy_a/busy_b        - busy bits of the read addresses
//   busy_vec             - all busy bits
module reg_file_gen
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH  = WORD_W,
  parameter int unsigned DEPTH  = NUM_GPR,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned BYPASS = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [WIDTH-1:0]  rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_b,
  input  logic              BAout,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              busy_a,
  output logic              busy_b,
  output logic [DEPTH-1:0]  busy_vec
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             fwd_en;

  // A write only commits (and only forwards) when not in reset.
  assign fwd_en = wr_en & clr;

  // Storage next state.
  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  // Scoreboard next state; reserve applied last so a new reservation
  // supersedes a release of the same register.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (rsv_en) begin
      busy_d[rsv_addr] = 1'b1;
    end
  end

  // Storage and scoreboard registers; reset discards any pending update.
  always_ff @(posedge clk) begin
    if (!clr) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

  reg_file_rdport #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .BYPASS(BYPASS)
  ) u_rdport_a (
    .rd_addr (rd_addr_a),
    .ba_out  (BAout),
    .fwd_en  (fwd_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .regs    (regs_q),
    .busy_vec(busy_q),
    .rd_data (rd_data_a),
    .busy    (busy_a)
  );

  reg_file_rdport #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .BYPASS(BYPASS)
  ) u_rdport_b (
    .rd_addr (rd_addr_b),
    .ba_out  (BAout),
    .fwd_en  (fwd_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .regs    (regs_q),
    .busy_vec(busy_q),
    .rd_data (rd_data_b),
    .busy    (busy_b)
  );

endmodule : reg_file_gen

// File: doc/reg_file_gen.md
Name: reg_file_gen

Overview:
Parametrised general-purpose register file. It is the successor to the single-register R0 block and replaces the per-register instances in the datapath.
- One synchronous write port and two combinational read ports (A, B).
- Optional write-to-read bypass.
- Per-port BAout zero-gating of register 0.
- Busy-bit scoreboard: the control unit reserves destination registers at issue, and writeback releases them.
- Sits between the bus/writeback path and the ALU operand (A/B) inputs.

Parameters:
- WIDTH, 32: data width of every register.
- DEPTH, 16: number of registers; must be a power of 2, ≥2.
- ADDR_W, $clog2(DEPTH): address width (derived; do not override).
- BYPASS, 1: 1 = same-cycle write data is forwarded to matching reads; 0 = reads return stored value only.

Ports:
- clk  in  1  rising-edge clock
- clr  in  1  reset; synchronous, active-low (0 = reset)
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write register index
- wr_data  in  WIDTH  write data
- rd_addr_a  in  ADDR_W  read port A index
- rd_data_a  out  WIDTH  read port A data
- rd_addr_b  in  ADDR_W  read port B index
- rd_data_b  out  WIDTH  read port B data
- BAout  in  1  base-address mode; when 1, register 0 reads as zero on both ports
- rsv_en  in  1  reserve strobe; marks rsv_addr busy
- rsv_addr  in  ADDR_W  register to reserve
- busy_a  out  1  busy bit of rd_addr_a
- busy_b  out  1  busy bit of rd_addr_b
- busy_vec  out  DEPTH  all busy bits, bit i = register i

Behaviour:
- Reset: on a rising clk edge with clr=0:
  - all DEPTH registers and busy bits go to 0;
  - wr_en and rsv_en are ignored that cycle.
- Outputs after reset: rd_data_* = 0 (unless bypass is active), busy_* = 0, busy_vec = 0.
- Reset taking effect mid-operation discards any pending write or reservation in that cycle.
- Write:
  - on a rising edge with clr=1 and wr_en=1, reg[wr_addr] <= wr_data;
  - the write is visible through the storage path on the next cycle (1-cycle latency);
  - register 0 is writable and stores normally; BAout gates only its read.
- Read: combinational, in priority order:
  1. BAout=1 and rd_addr_x=0 → rd_data_x = 0, regardless of bypass or a pending write.
  2. BYPASS=1 and wr_en=1 and clr=1 and wr_addr=rd_addr_x → rd_data_x = wr_data (zero-latency forward).
  3. Otherwise rd_data_x = reg[rd_addr_x].
- Both read ports are independent. Both may address the same register and return identical data.
- Scoreboard, per busy bit i, at each rising edge with clr=1:
  - set if rsv_en=1 and rsv_addr=i;
  - else cleared if wr_en=1 and wr_addr=i;
  - else held.
  - Simultaneous reserve and write to the same register: set wins, because the new reservation supersedes the retiring one.
  - Reserve and write to different registers in the same cycle: both take effect.
  - A write to a non-busy register is legal; its busy bit stays 0.
  - Reserving an already-busy register is legal; the bit stays 1.
- busy_a / busy_b: registered state only, read combinationally from busy_vec. They are not bypassed; a same-cycle release is seen on the next cycle.
- No X propagation: addresses are always in range because DEPTH is a power of 2.

Decomposition:
- Shared package (cpu_pkg): WORD_W=32, NUM_GPR=16, GPR_ADDR_W=4, and localparam R0_IDX=0.
- One natural sub-module: reg_file_rdport. It implements one read port (BAout gating, bypass mux, busy lookup) and is instantiated twice.
- Storage and scoreboard stay in the top module.

Test Plan:
1. Reset (clr=0 for 2 cycles with wr_en=1, wr_addr=3, wr_data=32'hDEAD_BEEF) → after release, reading reg 3 gives 0, busy_vec=16'h0000.
2. Write/readback: write reg 5 = 32'h1234_5678; next cycle rd_addr_a=5 → 32'h1234_5678. With BYPASS=1, same-cycle rd_addr_b=5 during the write → 32'h1234_5678. With BYPASS=0 the same-cycle read gives the old value 0.
3. BAout gating: write reg 0 = 32'hAAAA_5555; BAout=0 → rd_data_a=32'hAAAA_5555; BAout=1 → rd_data_a=rd_data_b=0. During a write to reg 0 with BAout=1 and BYPASS=1 → still 0.
4. Scoreboard: rsv_en to reg 7 → next cycle busy_vec[7]=1 and busy_a=1 (rd_addr_a=7). Write to reg 7 → next cycle busy_vec[7]=0.
5. Simultaneous events: reg 9 busy, then in one cycle rsv_addr=9 and wr_addr=9 → busy_vec[9] stays 1 and reg 9 holds the written data. rsv_addr=2 with wr_addr=9 → busy_vec[2]=1, busy_vec[9]=0.
6. Reset mid-operation: regs 1 and 4 busy with data 32'h0000_0011; assert clr=0 together with rsv_en=1 (rsv_addr=6) → all registers 0, busy_vec=0, reg 6 not busy.
